// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Purpose : fetch_entry_t (PC + instruction pair), NOP encoding, default reset PC
//           and a word-alignment helper used by the fetch stage and its FIFOs.
// Ports   : none (package).

package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bundle
//
// Purpose : groups the fetch-side request channel (valid/ready/addr) and the
//           in-order, no-backpressure response channel (valid/data).
// Modports: master - fetch stage (drives requests, receives responses)
//           slave  - instruction memory (accepts requests, drives responses)

interface fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch_entry_t
//
// Purpose : small power-of-two deep FIFO with synchronous clear; head is a
//           combinational read of the oldest entry.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           push, push_data - write request and entry
//           pop             - remove head (ignored when empty)
//           clear           - drop all entries (same cycle push/pop ignored)
//           full, empty     - occupancy flags
//           count           - number of valid entries
//           head            - oldest entry (undefined contents when empty)

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic           do_push;
    logic           do_pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction fetch stage (IF/ID producer)
//
// Purpose : owns the PC, issues in-order fetches, pairs returned words with
//           their PCs and presents them to the IF/ID buffer; honours stall
//           (hold head) and flush (redirect, discard in-flight responses).
// Optional: FETCH_PERF_EN adds perf_fetched, perf_stall_cycles, perf_flushes.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           stall           - IF/ID not accepting; hold head entry
//           flush           - redirect from EX; redirect_pc is the new PC
//           imem            - instruction memory request/response (master)
//           if_valid        - instruction_IF / pc_out valid
//           instruction_IF  - instruction to IF/ID (NOP when empty)
//           pc_out          - PC of instruction_IF (0 when empty)

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [31:0]        redirect_pc,
    fetch_unit_if.master       imem,
    output logic               if_valid,
    output logic [31:0]        instruction_IF,
    output logic [31:0]        pc_out
`ifdef FETCH_PERF_EN
   ,output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall_cycles,
    output logic [15:0]        perf_flushes
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt;
    logic [SW-1:0] in_use;

    logic          req_valid;
    logic          accept;
    logic          rsp_valid;
    logic          rsp_keep;

    fetch_entry_t  tag_in;
    fetch_entry_t  tag_head;
    logic          tag_full;
    logic          tag_empty;
    logic [CW-1:0] tag_count;

    fetch_entry_t  q_in;
    fetch_entry_t  q_head;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic          q_push;
    logic          q_pop;

    // Credit: every accepted request already owns a queue slot, so the
    // response queue can never overflow.
    assign in_use    = SW'(outstanding) + SW'(q_count);
    assign req_valid = !rst && !flush && (in_use < SW'(FIFO_DEPTH));
    assign accept    = req_valid && imem.imem_req_ready;
    assign rsp_valid = imem.imem_rsp_valid;

    // Responses belonging to requests issued before a flush are dropped
    // until discard_cnt drains; they have no tag any more.
    assign rsp_keep  = rsp_valid && !flush && (discard_cnt == '0);

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = word_align(pc);

    assign tag_in = '{pc: word_align(pc), instr: '0};
    assign q_in   = '{pc: tag_head.pc, instr: imem.imem_rsp_data};
    assign q_push = rsp_keep;
    assign q_pop  = if_valid && !stall && !flush;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (tag_in),
        .pop       (rsp_keep),
        .clear     (flush),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count),
        .head      (tag_head)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_rsp_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .clear     (flush),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head      (q_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (flush) begin
            pc <= word_align(redirect_pc);
        end else if (accept) begin
            pc <= pc + 32'd4;
        end
    end

    // outstanding counts every accepted request until its response returns,
    // including those that will be discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            unique case ({accept, rsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            discard_cnt <= '0;
        end else if (flush) begin
            discard_cnt <= outstanding - CW'(rsp_valid);
        end else if (rsp_valid && (discard_cnt != '0)) begin
            discard_cnt <= discard_cnt - 1'b1;
        end
    end

    always_comb begin
        if_valid       = 1'b0;
        instruction_IF = NOP_INSTR;
        pc_out         = 32'h0;
        if (rst) begin
            instruction_IF = 32'h0;
        end else if (!q_empty) begin
            if_valid       = 1'b1;
            instruction_IF = q_head.instr;
            pc_out         = q_head.pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (q_pop)              perf_fetched      <= perf_fetched + 32'd1;
            if (if_valid && stall)  perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush)              perf_flushes      <= perf_flushes + 16'd1;
        end
    end
`endif

    // Tag FIFO status and its unused instr field are only consumed below.
    logic tag_unused;
    assign tag_unused = &{1'b0, tag_head.instr, tag_full, tag_empty, tag_count};

`ifndef SYNTHESIS
    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (rst)
        imem.imem_rsp_valid |-> (outstanding != '0));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        q_push |-> !q_full);
    a_no_tag_overflow: assert property (@(posedge clk) disable iff (rst)
        accept |-> !tag_full);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] instruction_IF;
    logic [31:0] pc_out;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;

    always #5 clk = ~clk;

    fetch_unit_if mif();
    fetch_unit_if wif();

`ifdef FETCH_PERF_EN
    logic [31:0] pf_fetched, pf_stall, wpf_fetched, wpf_stall;
    logic [15:0] pf_flushes, wpf_flushes;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .imem           (mif),
        .if_valid       (if_valid),
        .instruction_IF (instruction_IF),
        .pc_out         (pc_out)
`ifdef FETCH_PERF_EN
       ,.perf_fetched      (pf_fetched),
        .perf_stall_cycles (pf_stall),
        .perf_flushes      (pf_flushes)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .stall          (1'b0),
        .flush          (1'b0),
        .redirect_pc    (32'h0),
        .imem           (wif),
        .if_valid       (w_valid),
        .instruction_IF (w_instr),
        .pc_out         (w_pc)
`ifdef FETCH_PERF_EN
       ,.perf_fetched      (wpf_fetched),
        .perf_stall_cycles (wpf_stall),
        .perf_flushes      (wpf_flushes)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        exp_q[$];
    exp_t        exp_wrap[$];
    logic [31:0] exp_addr[$];
    logic [31:0] wrap_addr[$];
    pend_t       pend[$];

    int n_cmp   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int mem_lat = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Main instruction memory: in order, latency mem_lat cycles.
    initial begin
        mif.imem_rsp_valid = 1'b0;
        mif.imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mif.imem_rsp_valid = 1'b1;
                mif.imem_rsp_data  = mem_data(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                mif.imem_rsp_valid = 1'b0;
                mif.imem_rsp_data  = 32'h0;
            end
            @(negedge clk);
            if (rst) begin
                pend.delete();
            end else if (mif.imem_req_valid && mif.imem_req_ready) begin
                if (exp_addr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_req: got %h expected none", mif.imem_req_addr);
                end else begin
                    check("req_addr", mif.imem_req_addr, exp_addr.pop_front());
                end
                pend.push_back('{mif.imem_req_addr, cyc + mem_lat});
            end
        end
    end

    // Main output monitor.
    exp_t m_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && if_valid && !stall && !flush) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got pc %h instr %h expected none", pc_out, instruction_IF);
                end else begin
                    m_e = exp_q.pop_front();
                    check("out_pc", pc_out, m_e.pc);
                    check("out_instr", instruction_IF, m_e.instr);
                end
            end
        end
    end

    // Wrap instance: always-ready 1-cycle memory, first three fetches checked.
    logic        w_acc;
    logic [31:0] w_a;
    initial begin
        wif.imem_req_ready = 1'b1;
        wif.imem_rsp_valid = 1'b0;
        wif.imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            w_acc = !rst && wif.imem_req_valid && wif.imem_req_ready;
            w_a   = wif.imem_req_addr;
            if (w_acc && wrap_addr.size() > 0) check("wrap_addr", w_a, wrap_addr.pop_front());
            @(posedge clk);
            #1;
            wif.imem_rsp_valid = w_acc;
            wif.imem_rsp_data  = mem_data(w_a);
        end
    end

    exp_t w_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && w_valid && exp_wrap.size() > 0) begin
                w_e = exp_wrap.pop_front();
                check("wrap_pc", w_pc, w_e.pc);
                check("wrap_instr", w_instr, w_e.instr);
            end
        end
    end

    task automatic fetch_n(input int n);
        int got = 0;
        int t   = 0;
        mif.imem_req_ready = 1'b1;
        while (got < n && t < 60) begin
            @(negedge clk);
            t++;
            if (mif.imem_req_valid && mif.imem_req_ready) got++;
        end
        @(posedge clk);
        #1;
        mif.imem_req_ready = 1'b0;
        if (got < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_timeout: got %0d accepts expected %0d", got, n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        redirect_pc = 32'h0;
        mif.imem_req_ready = 1'b0;

        exp_wrap.push_back('{32'hFFFF_FFF8, 32'h3F21_FFF8});
        exp_wrap.push_back('{32'hFFFF_FFFC, 32'h3F21_FFFC});
        exp_wrap.push_back('{32'h0000_0000, 32'hC0DE_0000});
        wrap_addr.push_back(32'hFFFF_FFF8);
        wrap_addr.push_back(32'hFFFF_FFFC);
        wrap_addr.push_back(32'h0000_0000);

        // Reset
        repeat (2) begin
            @(negedge clk);
            check("rst_if_valid", if_valid, 1'b0);
            check("rst_req_valid", mif.imem_req_valid, 1'b0);
            check("rst_instr", instruction_IF, 32'h0);
            check("rst_pc_out", pc_out, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_req_valid", mif.imem_req_valid, 1'b1);
        check("first_req_addr", mif.imem_req_addr, 32'h0);
        check("empty_nop", instruction_IF, 32'h0000_0013);
        @(posedge clk);
        #1;

        // Streaming
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8);
        exp_addr.push_back(32'hC);
        exp_q.push_back('{32'h0, 32'hC0DE_0000});
        exp_q.push_back('{32'h4, 32'hC0DE_0004});
        exp_q.push_back('{32'h8, 32'hC0DE_0008});
        exp_q.push_back('{32'hC, 32'hC0DE_000C});
        fetch_n(4);
        idle(8);

        // Stall with two entries queued
        stall = 1'b1;
        exp_addr.push_back(32'h10);
        exp_addr.push_back(32'h14);
        exp_q.push_back('{32'h10, 32'hC0DE_0010});
        exp_q.push_back('{32'h14, 32'hC0DE_0014});
        fetch_n(2);
        repeat (3) begin
            @(negedge clk);
            check("stall_if_valid", if_valid, 1'b1);
            check("stall_head_pc", pc_out, 32'h10);
            check("stall_head_instr", instruction_IF, 32'hC0DE_0010);
            check("stall_no_credit", mif.imem_req_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        idle(6);

        // Flush with two requests in flight
        mem_lat = 4;
        exp_addr.push_back(32'h18);
        exp_addr.push_back(32'h1C);
        exp_addr.push_back(32'h100);
        exp_q.push_back('{32'h100, 32'hC0DE_0100});
        fetch_n(2);
        flush = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(posedge clk);
        #1;
        flush = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        check("post_flush_if_valid", if_valid, 1'b0);
        @(posedge clk);
        #1;
        fetch_n(1);
        idle(10);

        // Backpressure, then misaligned redirect
        repeat (3) begin
            @(negedge clk);
            check("bp_req_valid", mif.imem_req_valid, 1'b1);
            check("bp_req_addr", mif.imem_req_addr, 32'h104);
        end
        @(posedge clk);
        #1;
        flush = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(negedge clk);
        check("flush_forces_valid_low", mif.imem_req_valid, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("redirect_req_valid", mif.imem_req_valid, 1'b1);
        check("redirect_req_addr", mif.imem_req_addr, 32'h100);
        exp_addr.push_back(32'h100);
        exp_q.push_back('{32'h100, 32'hC0DE_0100});
        @(posedge clk);
        #1;
        fetch_n(1);
        idle(8);

        check("exp_q_drained", exp_q.size(), 0);
        check("exp_addr_drained", exp_addr.size(), 0);
        check("wrap_out_drained", exp_wrap.size(), 0);
        check("wrap_addr_drained", wrap_addr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
